rng_range_sampler: RTL and testbench
====================================

Name: rng_range_sampler

Overview:
- Downstream consumer of the 32-bit combined Tausworthe generator output.
- Converts the free-running uniform 32-bit stream into uniform integers in [0, LIMIT) by masked rejection sampling.
- Buffers accepted samples in a small show-ahead FIFO and presents them on a valid/ready interface to the consuming logic.
- Counts rejected candidates for statistics and debug.

Parameters:
- DEPTH, 8, FIFO depth in samples; power of two, 2..64.
- RESET_LIMIT, 32'd256, range limit loaded at reset.
- CNT_W, 16, width of the saturating reject counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high, single clock domain.
- rnd_in  in  32  random word from the generator.
- rnd_valid  in  1  rnd_in is valid this cycle; tied high when the generator free-runs.
- cfg_load  in  1  one-cycle pulse: load cfg_limit and flush.
- cfg_limit  in  32  new range limit N; a sample s satisfies 0 <= s < N.
- out_data  out  32  head-of-FIFO sample; reads 0 when out_valid=0.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer pops when out_valid & out_ready.
- cfg_err  out  1  loaded limit is 0; no samples are produced.
- rej_cnt  out  CNT_W  rejected candidates since the last reset or cfg_load; saturates at all-ones.

Behaviour:
- Reset values (rst=1 at an edge):
  - lim_q=RESET_LIMIT, mask_q derived from RESET_LIMIT.
  - FIFO empty, stage-1 valid=0.
  - out_valid=0, out_data=0, rej_cnt=0.
  - cfg_err=(RESET_LIMIT==0).
  - rst overrides all other inputs.
- Mask rule:
  - m=N-1, then OR-smear right by 1, 2, 4, 8 and 16. This gives the smallest 2^k-1 >= N-1.
  - N=1 gives mask 0 (always sample 0). N=0 gives mask all-ones, but cfg_err=1.
  - The mask is computed combinationally from cfg_limit and registered at cfg_load.
- Stage 1, at an edge with rnd_valid=1, cfg_load=0 and cfg_err=0:
  - Register cand=rnd_in & mask_q and acc=(cand < lim_q), using a 32-bit unsigned compare.
  - Stage-1 valid follows rnd_valid.
- Stage 2, next edge:
  - If stage-1 valid & acc and the FIFO is not full (or is popped this same edge), write cand.
  - If stage-1 valid & ~acc, increment rej_cnt, saturating at all-ones.
  - If accepted but the FIFO is full and not popped, drop cand silently. The generator is not stalled and rej_cnt is unchanged.
- Latency: rnd_in sampled at edge E gives out_valid=1 after edge E+1, provided the FIFO was empty and the candidate was accepted. That is 2 cycles.
- Throughput: at most one accepted sample per cycle.
- FIFO:
  - Show-ahead: out_data is the head entry combinationally from FIFO storage.
  - A pop occurs on an edge with out_valid & out_ready.
  - Push and pop on the same edge: occupancy is unchanged, and this is allowed when full.
  - Pop when empty is ignored.
  - Read and write pointers are log2(DEPTH)+1 bits, wrapping naturally; full/empty come from MSB compare.
- cfg_load edge:
  - lim_q<=cfg_limit, mask_q<=mask(cfg_limit), cfg_err<=(cfg_limit==0).
  - FIFO flushed, stage-1 valid cleared, rej_cnt<=0.
  - rnd_in and out_ready in that cycle are ignored.
  - Sampling resumes with the next cycle's rnd_in.
- While cfg_err=1: stage 1 never goes valid, out_valid stays 0, and rej_cnt holds.

Decomposition:
- Shared package rng_pkg holds:
  - RNG_W=32;
  - function range_mask(N) implementing the OR-smear;
  - the default RESET_LIMIT constant.
- One sub-module, rng_sample_fifo (parameter DEPTH, width RNG_W, synchronous flush input). It holds the show-ahead storage, pointers and full/empty logic.
- The sampler top holds the config registers, stage 1, the accept logic and the counter.

Test Plan:
- N=10 (mask 0xF). rnd_in sequence 0x00000003, 0xFFFFFFFC, 0x12345679 with out_ready=1 → out_data 3 then 9; rej_cnt=1; first out_valid 2 cycles after the first word.
- N=1. Any rnd_in such as 0xDEADBEEF → every output is 0; rej_cnt stays 0.
- N=0 via cfg_load → cfg_err=1, out_valid never asserts, rej_cnt=0.
- DEPTH=8, out_ready=0, N=256, rnd_in=0x00000001..0x0000000C → FIFO holds 1..8 and values 9..12 are dropped. Then raise out_ready → reads 1..8, then out_valid=0.
- FIFO full with continuous accepted input and out_ready=1 → one push and one pop per edge, no drops, strictly in-order output.
- cfg_load mid-stream with 3 entries queued, new N=100 → out_valid=0 on the next cycle and rej_cnt=0. Later outputs are all <100.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared definitions for the random-range sampler: word width, default limit
// and the power-of-two mask used for rejection sampling.
package rng_pkg;

  localparam int RNG_W = 32;
  localparam logic [RNG_W-1:0] RESET_LIMIT_DEF = 32'd256;

  // Smallest 2^k-1 covering n-1; n=0 wraps to all-ones.
  function automatic logic [RNG_W-1:0] range_mask(input logic [RNG_W-1:0] n);
    logic [RNG_W-1:0] m;
    m = n - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/rng_sample_fifo.sv
// Show-ahead FIFO of accepted samples with synchronous flush; the head entry is
// visible combinationally, and a write is taken when full only if a pop happens on the same edge.
module rng_sample_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [RNG_W-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [RNG_W-1:0] head_dat_o,
  output logic             head_vld_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [RNG_W-1:0] mem_q [DEPTH];
  logic             empty, rd_en, wr_en;

  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_en      = pop_i & ~empty;
    wr_en      = push_i & (~full_o | rd_en);
    head_vld_o = ~empty;
    head_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/rng_range_sampler.sv
// Masked rejection sampler mapping a free-running 32-bit stream onto [0, N);
// 2-cycle latency to out_valid; a full FIFO drops accepted samples, so the generator is never stalled.
module rng_range_sampler
  import rng_pkg::*;
#(
  parameter int               DEPTH       = 8,
  parameter logic [RNG_W-1:0] RESET_LIMIT = RESET_LIMIT_DEF,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RNG_W-1:0] rnd_in,
  input  logic             rnd_valid,
  input  logic             cfg_load,
  input  logic [RNG_W-1:0] cfg_limit,
  output logic [RNG_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] rej_cnt
);

  logic [RNG_W-1:0] lim_q, mask_q, s1_cand_q, cand_d;
  logic             cfg_err_q, s1_vld_q, s1_acc_q, acc_d, s1_go, push;
  logic [CNT_W-1:0] rej_q, rej_d;
  logic             fifo_full;

  always_comb begin
    cand_d = rnd_in & mask_q;
    acc_d  = (cand_d < lim_q);
    s1_go  = rnd_valid & ~cfg_err_q;
    push   = s1_vld_q & s1_acc_q;
    rej_d  = rej_q;
    if (s1_vld_q && !s1_acc_q && !(&rej_q)) rej_d = rej_q + CNT_W'(1);
  end

  // cfg_load discards the in-flight candidate and restarts statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      lim_q     <= RESET_LIMIT;
      mask_q    <= range_mask(RESET_LIMIT);
      cfg_err_q <= (RESET_LIMIT == '0);
      s1_vld_q  <= 1'b0;
      s1_acc_q  <= 1'b0;
      s1_cand_q <= '0;
      rej_q     <= '0;
    end else if (cfg_load) begin
      lim_q     <= cfg_limit;
      mask_q    <= range_mask(cfg_limit);
      cfg_err_q <= (cfg_limit == '0);
      s1_vld_q  <= 1'b0;
      rej_q     <= '0;
    end else begin
      s1_vld_q <= s1_go;
      if (s1_go) begin
        s1_cand_q <= cand_d;
        s1_acc_q  <= acc_d;
      end
      rej_q <= rej_d;
    end
  end

  rng_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (cfg_load),
    .push_i     (push),
    .push_dat_i (s1_cand_q),
    .pop_i      (out_ready),
    .head_dat_o (out_data),
    .head_vld_o (out_valid),
    .full_o     (fifo_full)
  );

  assign cfg_err = cfg_err_q;
  assign rej_cnt = rej_q;

endmodule

// File: tb/tb_rng_range_sampler.sv
// Directed bench for rng_range_sampler: single-word vector table plus
// hand-written multi-cycle sequences (latency, overflow drop, full-flow, reload).
module tb_rng_range_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rnd_in;
  logic        rnd_valid;
  logic        cfg_load;
  logic [31:0] cfg_limit;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_err;
  logic [15:0] rej_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] got [$];

  always #5 clk = ~clk;

  rng_range_sampler #(.DEPTH(8), .RESET_LIMIT(32'd256), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .cfg_load  (cfg_load),
    .cfg_limit (cfg_limit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_err   (cfg_err),
    .rej_cnt   (rej_cnt)
  );

  typedef struct {
    logic [31:0] limit;
    logic [31:0] rnd;
    logic        exp_vld;
    logic [31:0] exp_dat;
    logic [15:0] exp_rej;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; record any pop it causes.
  task automatic cyc(input logic rv, input logic [31:0] rin, input logic ordy);
    @(negedge clk);
    if (out_valid && ordy) got.push_back(out_data);
    cfg_load  = 1'b0;
    rnd_valid = rv;
    rnd_in    = rin;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Junk word and out_ready=1 during the load cycle must both be ignored.
  task automatic load(input logic [31:0] lim);
    @(negedge clk);
    cfg_load  = 1'b1;
    cfg_limit = lim;
    rnd_valid = 1'b1;
    rnd_in    = 32'h0000_0001;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    rnd_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'd10,         32'h0000_0003, 1'b1, 32'd3,          16'd0};
    vecs[1]  = '{32'd10,         32'hFFFF_FFFC, 1'b0, 32'd0,          16'd1};
    vecs[2]  = '{32'd10,         32'h1234_5679, 1'b1, 32'd9,          16'd0};
    vecs[3]  = '{32'd1,          32'hDEAD_BEEF, 1'b1, 32'd0,          16'd0};
    vecs[4]  = '{32'd256,        32'h1234_5678, 1'b1, 32'h78,         16'd0};
    vecs[5]  = '{32'd100,        32'h0000_00FF, 1'b0, 32'd0,          16'd1};
    vecs[6]  = '{32'd100,        32'h0000_0063, 1'b1, 32'd99,         16'd0};
    vecs[7]  = '{32'd100,        32'h0000_0064, 1'b0, 32'd0,          16'd1};
    vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF,  16'd0};
    vecs[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 32'd0,          16'd1};
    vecs[10] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFE,  16'd0};
    vecs[11] = '{32'd3,          32'h0000_0007, 1'b0, 32'd0,          16'd1};
    vecs[12] = '{32'd3,          32'h0000_0006, 1'b1, 32'd2,          16'd0};

    rst = 1'b1; rnd_in = 32'hFFFF_FFFF; rnd_valid = 1'b1; cfg_load = 1'b1;
    cfg_limit = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset rej_cnt", 32'(rej_cnt), 32'd0);
    chk("reset cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b0; cfg_load = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;

    foreach (vecs[i]) begin
      load(vecs[i].limit);
      cyc(1'b1, vecs[i].rnd, 1'b0);
      chk($sformatf("vec%0d early valid", i), 32'(out_valid), 32'd0);
      cyc(1'b0, 32'd0, 1'b0);
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d data", i), out_data, vecs[i].exp_dat);
      chk($sformatf("vec%0d rej", i), 32'(rej_cnt), 32'(vecs[i].exp_rej));
    end

    // N=10 back-to-back stream, consumer always ready.
    load(32'd10);
    got.delete();
    cyc(1'b1, 32'h0000_0003, 1'b1);
    chk("stream latency E", 32'(out_valid), 32'd0);
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("stream latency E+1", 32'(out_valid), 32'd1);
    chk("stream first data", out_data, 32'd3);
    cyc(1'b1, 32'h1234_5679, 1'b1);
    repeat (4) cyc(1'b0, 32'd0, 1'b1);
    chk("stream count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("stream out0", got[0], 32'd3);
      chk("stream out1", got[1], 32'd9);
    end
    chk("stream rej", 32'(rej_cnt), 32'd1);

    // N=0: error flag, nothing produced, counter frozen.
    load(32'd0);
    chk("n0 cfg_err", 32'(cfg_err), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        cyc(1'b1, 32'h0000_0100 + 32'(i), 1'b1);
        if (out_valid) seen++;
      end
      chk("n0 out_valid seen", 32'(seen), 32'd0);
    end
    chk("n0 rej", 32'(rej_cnt), 32'd0);

    // Overflow: words 9..12 are dropped while the consumer stalls.
    load(32'd256);
    chk("n256 cfg_err", 32'(cfg_err), 32'd0);
    got.delete();
    for (int i = 1; i <= 12; i++) cyc(1'b1, 32'(i), 1'b0);
    repeat (2) cyc(1'b0, 32'd0, 1'b0);
    chk("ovf rej", 32'(rej_cnt), 32'd0);
    chk("ovf head", out_data, 32'd1);
    repeat (10) cyc(1'b0, 32'd0, 1'b1);
    chk("ovf count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk($sformatf("ovf out%0d", i), got[i], 32'(i + 1));
    chk("ovf drained", 32'(out_valid), 32'd0);

    // Full FIFO with simultaneous push and pop every edge.
    load(32'd256);
    got.delete();
    for (int i = 1; i <= 9; i++) cyc(1'b1, 32'(i), 1'b0);
    for (int i = 10; i <= 20; i++) cyc(1'b1, 32'(i), 1'b1);
    repeat (12) cyc(1'b0, 32'd0, 1'b1);
    chk("full count", 32'(got.size()), 32'd20);
    begin
      int bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== 32'(i + 1)) bad++;
      chk("full order", 32'(bad), 32'd0);
    end
    chk("full drained", 32'(out_valid), 32'd0);

    // Reload mid-stream with three entries queued and one reject counted.
    load(32'd200);
    got.delete();
    cyc(1'b1, 32'd1, 1'b0);
    cyc(1'b1, 32'd2, 1'b0);
    cyc(1'b1, 32'd3, 1'b0);
    cyc(1'b1, 32'h0000_00FF, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("pre-reload rej", 32'(rej_cnt), 32'd1);
    chk("pre-reload valid", 32'(out_valid), 32'd1);
    load(32'd100);
    chk("reload valid", 32'(out_valid), 32'd0);
    chk("reload rej", 32'(rej_cnt), 32'd0);
    cyc(1'b1, 32'h0000_0063, 1'b1);
    cyc(1'b1, 32'h0000_00E4, 1'b1);
    cyc(1'b1, 32'hAAAA_AAAA, 1'b1);
    cyc(1'b1, 32'h0000_007F, 1'b1);
    repeat (4) cyc(1'b0, 32'd0, 1'b1);
    chk("reload count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("reload out0", got[0], 32'd99);
      chk("reload out1", got[1], 32'd42);
    end
    chk("reload rej after", 32'(rej_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
